// File: rtl/inst_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the instruction encoder.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [3:0]        alu_fn;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       instr_index;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_word;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, op_sel, alu_fn, rs, rt, rd, shamt, imm, instr_index, out_ready,
        input  in_ready, out_valid, out_word, out_addr
    );

    modport slave (
        input  in_valid, op_sel, alu_fn, rs, rt, rd, shamt, imm, instr_index, out_ready,
        output in_ready, out_valid, out_word, out_addr
    );
endinterface

// File: rtl/inst_encoder.sv
// Assembles MIPS instruction words from decoded fields, buffers them in a FIFO
// and streams each word with its instruction-memory byte address.
module inst_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_encoder_if.slave     bus,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear_err,
    output logic              err,
    output logic [7:0]        illegal_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'd0,
        OP_ADDIU = 4'd1,
        OP_ADDI  = 4'd2,
        OP_ANDI  = 4'd3,
        OP_ORI   = 4'd4,
        OP_XORI  = 4'd5,
        OP_SLTI  = 4'd6,
        OP_LW    = 4'd7,
        OP_SW    = 4'd8,
        OP_BEQ   = 4'd9,
        OP_BNE   = 4'd10,
        OP_J     = 4'd11
    } op_e;

    logic [5:0]        funct;
    logic              fn_ok;
    logic [5:0]        opcode;
    logic              enc_ok;
    logic [31:0]       enc_word;
    logic              accept;
    logic              push;
    logic              pop;
    logic              illegal;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              rdy_q;
    logic [ADDR_W-1:0] addr_q;

    always_comb begin
        funct = '0;
        fn_ok = 1'b1;
        case (bus.alu_fn)
            4'b0000: funct = 6'b100000;
            4'b0001: funct = 6'b100010;
            4'b0010: funct = 6'b100101;
            4'b0011: funct = 6'b100100;
            4'b0100: funct = 6'b100110;
            4'b0110: funct = 6'b000100;
            4'b1000: funct = 6'b101010;
            4'b1111: funct = 6'b100111;
            default: fn_ok = 1'b0;
        endcase
    end

    always_comb begin
        opcode = '0;
        enc_ok = 1'b1;
        case (bus.op_sel)
            OP_RTYPE: enc_ok = fn_ok;
            OP_ADDIU: opcode = 6'b001001;
            OP_ADDI:  opcode = 6'b001000;
            OP_ANDI:  opcode = 6'b001100;
            OP_ORI:   opcode = 6'b001101;
            OP_XORI:  opcode = 6'b001110;
            OP_SLTI:  opcode = 6'b001010;
            OP_LW:    opcode = 6'b100011;
            OP_SW:    opcode = 6'b101011;
            OP_BEQ:   opcode = 6'b000100;
            OP_BNE:   opcode = 6'b000101;
            OP_J:     opcode = 6'b000010;
            default:  enc_ok = 1'b0;
        endcase
        if (bus.op_sel == OP_RTYPE)
            enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, funct};
        else if (bus.op_sel == OP_J)
            enc_word = {opcode, bus.instr_index};
        else
            enc_word = {opcode, bus.rs, bus.rt, bus.imm};
    end

    assign accept  = bus.in_valid & bus.in_ready;
    assign push    = accept & enc_ok;
    assign illegal = accept & ~enc_ok;
    assign pop     = bus.out_valid & bus.out_ready;

    always_comb begin
        cnt_nxt = count;
        case ({push, pop})
            2'b10:   cnt_nxt = count + CNT_W'(1);
            2'b01:   cnt_nxt = count - CNT_W'(1);
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_word;
    end

    // in_ready is a registered view of the post-update occupancy, so a pop
    // from a full FIFO opens the input only on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= cnt_nxt;
            rdy_q <= (cnt_nxt < CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (load_base) begin
            addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
        end else if (pop) begin
            addr_q <= addr_q + ADDR_W'(4);
        end
    end

    // An illegal accept coinciding with clear_err leaves exactly one recorded error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err         <= 1'b0;
            illegal_cnt <= '0;
        end else if (illegal) begin
            err <= 1'b1;
            if (clear_err)
                illegal_cnt <= 8'd1;
            else if (illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + 8'd1;
        end else if (clear_err) begin
            err         <= 1'b0;
            illegal_cnt <= '0;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_word  = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.out_addr  = addr_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: queue-based reference model checked every
// cycle, plus literal expectations taken from hand-assembled instruction words.
module tb_inst_encoder;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_base = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              clear_err = 1'b0;
    logic              err;
    logic [7:0]        illegal_cnt;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .load_base   (load_base),
        .base_addr   (base_addr),
        .clear_err   (clear_err),
        .err         (err),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: opcode table indexed by class, funct by ALU code.
    function automatic logic [32:0] model_enc(input logic [3:0] op, input logic [3:0] fn,
                                              input logic [4:0] s, input logic [4:0] t,
                                              input logic [4:0] d, input logic [4:0] sh,
                                              input logic [15:0] im, input logic [25:0] idx);
        logic [5:0] opc_tab [12];
        logic [5:0] f;
        logic       ok;
        opc_tab = '{6'd0, 6'd9, 6'd8, 6'd12, 6'd13, 6'd14, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
        ok = 1'b1;
        f  = 6'd0;
        case (fn)
            4'd0:  f = 6'd32;
            4'd1:  f = 6'd34;
            4'd2:  f = 6'd37;
            4'd3:  f = 6'd36;
            4'd4:  f = 6'd38;
            4'd6:  f = 6'd4;
            4'd8:  f = 6'd42;
            4'd15: f = 6'd39;
            default: ok = 1'b0;
        endcase
        if (op > 4'd11)  return {1'b0, 32'd0};
        if (op == 4'd0)  return {ok, 6'd0, s, t, d, sh, f};
        if (op == 4'd11) return {1'b1, 6'd2, idx};
        return {1'b1, opc_tab[op], s, t, im};
    endfunction

    logic [31:0]       m_q[$];
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_err = 1'b0;
    int unsigned       m_cnt = 0;
    logic              m_rdy = 1'b0;
    logic              started = 1'b0;

    initial forever begin
        logic [32:0] e;
        logic acc, pp;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_addr = '0;
            m_err = 1'b0;
            m_cnt = 0;
            m_rdy = 1'b0;
            started = 1'b1;
        end else begin
            acc = bus.in_valid && m_rdy;
            pp  = bus.out_ready && (m_q.size() != 0);
            e = model_enc(bus.op_sel, bus.alu_fn, bus.rs, bus.rt, bus.rd, bus.shamt,
                          bus.imm, bus.instr_index);
            if (pp) void'(m_q.pop_front());
            if (acc && e[32]) m_q.push_back(e[31:0]);
            if (load_base) m_addr = {base_addr[ADDR_W-1:2], 2'b00};
            else if (pp) m_addr = m_addr + 4;
            if (clear_err) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
            if (acc && !e[32]) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            m_rdy = (m_q.size() < DEPTH);
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("model_out_valid", 64'(bus.out_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) chk("model_out_word", 64'(bus.out_word), 64'(m_q[0]));
            chk("model_out_addr", 64'(bus.out_addr), 64'(m_addr));
            chk("model_in_ready", 64'(bus.in_ready), 64'(m_rdy));
            chk("model_err", 64'(err), 64'(m_err));
            chk("model_illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [3:0] op, input logic [3:0] fn, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [15:0] im, input logic [25:0] idx);
        int unsigned n = 0;
        bus.op_sel = op; bus.alu_fn = fn; bus.rs = s; bus.rt = t; bus.rd = d;
        bus.shamt = sh; bus.imm = im; bus.instr_index = idx;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL push_timeout: in_ready got 0 expected 1 at %0t", $time);
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_sel = '0; bus.alu_fn = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus.shamt = '0; bus.imm = '0; bus.instr_index = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_word", 64'(bus.out_word), 64'd0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic R-type, one-cycle latency
        push(4'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("rtype_valid", 64'(bus.out_valid), 64'd1);
        chk("rtype_word", 64'(bus.out_word), 64'h00221820);
        chk("rtype_addr", 64'(bus.out_addr), 64'h0);
        pop_one();
        push(4'd0, 4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("nor_word", 64'(bus.out_word), 64'h00221827);
        pop_one();
        push(4'd0, 4'd6, 5'd7, 5'd9, 5'd10, 5'd4, 16'h0, 26'h0);
        pop_one();
        push(4'd0, 4'd8, 5'd31, 5'd0, 5'd17, 5'd0, 16'h0, 26'h0);
        pop_one();

        // Base load with unaligned address, ADDIU + J
        load_base = 1'b1; base_addr = 32'h00400003;
        @(posedge clk); #1;
        load_base = 1'b0;
        push(4'd1, 4'd0, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        push(4'd11, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        chk("addiu_word", 64'(bus.out_word), 64'h2408FFFF);
        chk("addiu_addr", 64'(bus.out_addr), 64'h00400000);
        pop_one();
        chk("j_word", 64'(bus.out_word), 64'h08100000);
        chk("j_addr", 64'(bus.out_addr), 64'h00400004);
        pop_one();

        // Fill to DEPTH with consumer stalled
        for (int unsigned i = 0; i < DEPTH; i++)
            push(4'd4, 4'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i), 26'h0);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        idle(2);
        chk("full_hold_word", 64'(bus.out_word), 64'h34220000);
        chk("full_hold_addr", 64'(bus.out_addr), 64'h00400008);
        bus.out_ready = 1'b1;
        chk("pop_cycle_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("after_pop_in_ready", 64'(bus.in_ready), 64'd1);
        chk("after_pop_word", 64'(bus.out_word), 64'h34220001);
        chk("after_pop_addr", 64'(bus.out_addr), 64'h0040000C);
        idle(3);
        bus.out_ready = 1'b0;
        idle(1);
        chk("drained_valid", 64'(bus.out_valid), 64'd0);

        // Illegal requests and clear_err
        push(4'd13, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        push(4'd0, 4'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        idle(1);
        chk("illegal_no_emit", 64'(bus.out_valid), 64'd0);
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_cnt2", 64'(illegal_cnt), 64'd2);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        chk("clear_err", 64'(err), 64'd0);
        chk("clear_cnt", 64'(illegal_cnt), 64'd0);
        push(4'd14, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        clear_err = 1'b1;
        push(4'd12, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        clear_err = 1'b0;
        chk("clear_coincide_err", 64'(err), 64'd1);
        chk("clear_coincide_cnt", 64'(illegal_cnt), 64'd1);
        for (int unsigned i = 0; i < 256; i++)
            push(4'd15, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        chk("sat_cnt", 64'(illegal_cnt), 64'd255);
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;

        // Back-to-back with consumer always ready
        bus.out_ready = 1'b1;
        push(4'd9, 4'd0, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0003, 26'h0);
        chk("beq_word", 64'(bus.out_word), 64'h10850003);
        push(4'd10, 4'd0, 5'd4, 5'd5, 5'd0, 5'd0, 16'h0003, 26'h0);
        chk("bne_valid", 64'(bus.out_valid), 64'd1);
        chk("bne_word", 64'(bus.out_word), 64'h14850003);
        idle(1);
        bus.out_ready = 1'b0;
        push(4'd3, 4'd0, 5'd6, 5'd7, 5'd0, 5'd0, 16'h8001, 26'h0);
        push(4'd5, 4'd0, 5'd6, 5'd7, 5'd0, 5'd0, 16'h00F0, 26'h0);
        push(4'd6, 4'd0, 5'd6, 5'd7, 5'd0, 5'd0, 16'hFFFE, 26'h0);
        push(4'd2, 4'd0, 5'd6, 5'd7, 5'd0, 5'd0, 16'h1234, 26'h0);
        bus.out_ready = 1'b1;
        idle(5);
        bus.out_ready = 1'b0;

        // Address wrap and load-vs-pop priority
        load_base = 1'b1; base_addr = 32'hFFFFFFFF;
        @(posedge clk); #1;
        load_base = 1'b0;
        push(4'd11, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF);
        chk("wrap_word", 64'(bus.out_word), 64'h0BFFFFFF);
        chk("wrap_addr", 64'(bus.out_addr), 64'hFFFFFFFC);
        pop_one();
        push(4'd2, 4'd0, 5'd31, 5'd31, 5'd0, 5'd0, 16'h8000, 26'h0);
        chk("wrapped_addr", 64'(bus.out_addr), 64'h0);
        chk("addi_word", 64'(bus.out_word), 64'h23FF8000);
        pop_one();
        push(4'd8, 4'd0, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0);
        push(4'd7, 4'd0, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0);
        chk("sw_word", 64'(bus.out_word), 64'hAC430010);
        load_base = 1'b1; base_addr = 32'h00000100;
        pop_one();
        load_base = 1'b0;
        chk("load_wins_addr", 64'(bus.out_addr), 64'h00000100);
        chk("lw_word", 64'(bus.out_word), 64'h8C430010);
        pop_one();

        // Reset with words buffered
        for (int unsigned i = 0; i < 3; i++)
            push(4'd4, 4'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i + 16), 26'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_addr", 64'(bus.out_addr), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(4'd0, 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        chk("post_midrst_addr", 64'(bus.out_addr), 64'd0);
        chk("post_midrst_word", 64'(bus.out_word), 64'h00221820);
        pop_one();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: time got %0t expected < 200000", $time);
        $fatal(1);
    end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decoder: accepts decoded instruction fields (operation class, register numbers, shift, immediate/offset, jump index) over a valid/ready handshake.
- Assembles the 32-bit MIPS instruction word with the same opcode/funct map the decoder recognises.
- Buffers encoded words in a small FIFO and streams each word with its instruction-memory byte address to the imem loader.
- Used by the program loader and by self-checking benches to build instruction images.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, width of the instruction byte address.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- op_sel  input  4  class: 0 R-type, 1 ADDIU, 2 ADDI, 3 ANDI, 4 ORI, 5 XORI, 6 SLTI, 7 LW, 8 SW, 9 BEQ, 10 BNE, 11 J, 12-15 illegal.
- alu_fn  input  4  R-type function, using ALU control encoding.
- rs, rt, rd, shamt  input  5 each  register and shift fields.
- imm  input  16  immediate or branch offset.
- instr_index  input  26  jump target index.
- load_base  input  1  pulse; loads the address counter.
- base_addr  input  ADDR_W  new start address; bits [1:0] forced to 0.
- clear_err  input  1  clears err and illegal_cnt.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head.
- out_word  output  32  encoded instruction at head.
- out_addr  output  ADDR_W  byte address of head word.
- err  output  1  sticky illegal-request flag.
- illegal_cnt  output  8  saturating count of illegal requests.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FIFO empties.
  - out_valid=0, out_word=0, out_addr=0, err=0, illegal_cnt=0.
  - in_ready=0 during the reset cycle; in_ready=1 on the first cycle after reset.
  - Reset mid-stream discards all buffered words.
- Accept and push:
  - Accept occurs when in_valid & in_ready.
  - Encoding is combinational from the inputs; the word is written to the FIFO on the accept edge.
  - out_valid rises the next cycle when the FIFO was empty. Latency is 1 cycle.
- Pop: a pop occurs when out_valid & out_ready.
- in_ready = (count < DEPTH), registered from count, with no push/pop bypass. When the FIFO is full, in_ready stays low on the same cycle as a pop and rises the cycle after.
- Simultaneous push and pop when not full: count is unchanged and ordering is preserved.
- out_word and out_addr hold steady while out_valid=1 and out_ready=0.
- Encoding, with the I-type layout [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] imm:
  - R-type: {000000, rs, rt, rd, shamt, funct}. alu_fn→funct map: 0000→100000, 0001→100010, 0010→100101, 0011→100100, 0100→100110, 0110→000100, 1000→101010, 1111→100111.
  - I-type opcodes: ADDIU 001001, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, LW 100011, SW 101011, BEQ 000100, BNE 000101.
  - J: {000010, instr_index}.
  - No sign extension is performed; imm passes through verbatim.
- Illegal request: op_sel 12-15, or R-type with an unmapped alu_fn.
  - The request is accepted (handshake completes) but is not pushed.
  - err is set; illegal_cnt increments and saturates at 255.
- clear_err: zeroes err and illegal_cnt. If it coincides with an illegal accept, the result is err=1 and illegal_cnt=1.
- Address counter:
  - Resets to 0 and increments by 4 on each pop.
  - Wraps modulo 2^ADDR_W.
  - out_addr equals the counter.
  - load_base loads {base_addr[ADDR_W-1:2], 2'b00}. If load_base and a pop occur in the same cycle, load wins.
  - load_base does not flush the FIFO; the current head takes the new address.

Test Plan:
- Reset, then push op_sel=0, alu_fn=0000, rs=1, rt=2, rd=3, shamt=0 → one cycle later out_valid=1, out_word=0x00221820, out_addr=0.
- load_base with base_addr=0x00400003; push ADDIU rs=0, rt=8, imm=0xFFFF, then J instr_index=0x0100000 → words 0x2408FFFF @0x00400000 and 0x08100000 @0x00400004.
- Hold out_ready=0 and push DEPTH words → in_ready falls after the 4th accept. Pop once → in_ready returns the next cycle. All words emerge in order with addresses +4 each.
- Push op_sel=13, then R-type alu_fn=0101 → both accepted, nothing emitted, err=1, illegal_cnt=2. Pulse clear_err → 0/0.
- Continuous push and pop with out_ready=1: BEQ rs=4, rt=5, imm=0x0003 gives 0x10850003; BNE gives 0x14850003. Throughput is 1 word per cycle.
- Assert rst_n=0 with 3 words buffered → the next cycle out_valid=0 and out_addr=0. The next push emits at address 0.
